alu: RTL and testbench

- 4-function datapath ALU in the style of a DSP slice post-adder.
- Operates on three 18-bit operands (a, b, d) and one 48-bit operand (c).
- Produces a registered 48-bit result P, one clock after the operands and select are sampled.
- Used as a small arithmetic/logic stage ahead of accumulator and compare logic.

---
 rtl/alu_pkg.sv | 12 +
 rtl/alu_core.sv | 38 +++
 rtl/alu.sv | 89 ++++++++
 tb/tb_alu.sv | 94 +++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes and default widths for the alu post-adder slice.
package alu_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_CADD = 2'b10;
  localparam logic [1:0] OP_XOR  = 2'b11;

  localparam int AW_DEF = 18;
  localparam int PW_DEF = 48;

endpackage

// File: rtl/alu_core.sv
// Combinational part of the alu: operand sign-extension and the opcode mux.
module alu_core
  import alu_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int PW = PW_DEF
) (
  input  logic [AW-1:0] a,
  input  logic [AW-1:0] b,
  input  logic [PW-1:0] c,
  input  logic [AW-1:0] d,
  input  logic          carryin,
  input  logic [1:0]    select,
  output logic [PW-1:0] result
);

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] c_s;
  logic signed [PW-1:0] cin_ext;

  always_comb begin
    a_ext   = {{(PW-AW){a[AW-1]}}, a};
    b_ext   = {{(PW-AW){b[AW-1]}}, b};
    c_s     = c;
    cin_ext = {{(PW-1){1'b0}}, carryin};
    result  = '0;
    case (select)
      OP_ADD:  result = a_ext + b_ext;
      OP_SUB:  result = a_ext - b_ext;
      OP_CADD: result = c_s + a_ext + cin_ext;
      OP_XOR:  result = {{(PW-AW){1'b0}}, a ^ d};
      // X/Z select in simulation lands here and yields zero.
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Registered alu top: optional input register stage, alu_core, and the P flop.
module alu
  import alu_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int PW     = PW_DEF,
  parameter bit REG_IN = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] a,
  input  logic [AW-1:0] b,
  input  logic [PW-1:0] c,
  input  logic [AW-1:0] d,
  input  logic          carryin,
  input  logic [1:0]    select,
  output logic [PW-1:0] P
);

  logic [AW-1:0] a_in;
  logic [AW-1:0] b_in;
  logic [PW-1:0] c_in;
  logic [AW-1:0] d_in;
  logic          carryin_in;
  logic [1:0]    select_in;
  logic [PW-1:0] result;

  if (REG_IN) begin : g_in_reg
    logic [AW-1:0] a_p0;
    logic [AW-1:0] b_p0;
    logic [PW-1:0] c_p0;
    logic [AW-1:0] d_p0;
    logic          carryin_p0;
    logic [1:0]    select_p0;

    // Stage p0: optional operand capture
    always_ff @(posedge clk) begin
      if (rst) begin
        a_p0       <= '0;
        b_p0       <= '0;
        c_p0       <= '0;
        d_p0       <= '0;
        carryin_p0 <= 1'b0;
        select_p0  <= '0;
      end else begin
        a_p0       <= a;
        b_p0       <= b;
        c_p0       <= c;
        d_p0       <= d;
        carryin_p0 <= carryin;
        select_p0  <= select;
      end
    end

    assign a_in       = a_p0;
    assign b_in       = b_p0;
    assign c_in       = c_p0;
    assign d_in       = d_p0;
    assign carryin_in = carryin_p0;
    assign select_in  = select_p0;
  end else begin : g_no_in_reg
    assign a_in       = a;
    assign b_in       = b;
    assign c_in       = c;
    assign d_in       = d;
    assign carryin_in = carryin;
    assign select_in  = select;
  end

  alu_core #(
    .AW(AW),
    .PW(PW)
  ) u_core (
    .a      (a_in),
    .b      (b_in),
    .c      (c_in),
    .d      (d_in),
    .carryin(carryin_in),
    .select (select_in),
    .result (result)
  );

  // Stage p1: result register
  always_ff @(posedge clk) begin
    if (rst) P <= '0;
    else     P <= result;
  end

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: latency-1 instance plus a REG_IN=1 instance on shared inputs.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] a, b, d;
  logic [47:0] c;
  logic        carryin;
  logic [1:0]  select;
  logic [47:0] P;
  logic [47:0] P2;

  int checks = 0;
  int errors = 0;
  logic [47:0] exp_prev;

  always #5 clk = ~clk;

  alu #(.AW(18), .PW(48), .REG_IN(1'b0)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
    .carryin(carryin), .select(select), .P(P)
  );

  alu #(.AW(18), .PW(48), .REG_IN(1'b1)) dut_r2 (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
    .carryin(carryin), .select(select), .P(P2)
  );

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One operation: drive, clock, then compare both instances (REG_IN=1 lags by one op).
  task automatic run(input string tag, input logic [17:0] ta, input logic [17:0] tb_v,
                     input logic [47:0] tc, input logic [17:0] td, input logic tci,
                     input logic [1:0] ts, input logic [47:0] exp);
    a = ta; b = tb_v; c = tc; d = td; carryin = tci; select = ts;
    @(posedge clk); #1;
    check(tag, P, exp);
    check({tag, "_r2"}, P2, exp_prev);
    exp_prev = exp;
  endtask

  task automatic reset_cycle(input string tag);
    rst = 1'b1;
    a = 18'h2AAAA; b = 18'h15555; c = 48'hDEAD_BEEF_CAFE; d = 18'h3C3C3;
    carryin = 1'b1; select = 2'b10;
    @(posedge clk); #1;
    check(tag, P, 48'h0);
    check({tag, "_r2"}, P2, 48'h0);
    rst = 1'b0;
    exp_prev = 48'h0;
  endtask

  initial begin
    rst = 1'b1;
    a = '0; b = '0; c = '0; d = '0; carryin = 1'b0; select = 2'b00;
    exp_prev = 48'h0;
    @(posedge clk); #1;

    reset_cycle("rst0");
    rst = 1'b1;
    reset_cycle("rst1");

    run("rst_release_add", 18'd3, 18'd5, 48'd0, 18'd0, 1'b0, 2'b00, 48'd8);
    run("add_ci_ignored",  18'd3, 18'd5, 48'd0, 18'd0, 1'b1, 2'b00, 48'd8);
    run("sub_neg",         18'd3, 18'd5, 48'd0, 18'd0, 1'b1, 2'b01, 48'hFFFF_FFFF_FFFE);
    run("add_neg",         18'h3FFFF, 18'h20000, 48'd0, 18'd0, 1'b0, 2'b00, 48'hFFFF_FFFD_FFFF);
    run("cadd_ci",         18'd3, 18'd0, 48'd1024, 18'd0, 1'b1, 2'b10, 48'd1028);
    run("cadd_neg_a",      18'h3FFFF, 18'd0, 48'd1024, 18'd0, 1'b0, 2'b10, 48'd1023);
    run("xor_small",       18'd3, 18'd0, 48'd0, 18'd10, 1'b0, 2'b11, 48'd9);
    run("xor_no_sext",     18'h3FFFF, 18'd0, 48'd0, 18'd0, 1'b0, 2'b11, 48'h0000_0003_FFFF);
    run("cadd_wrap",       18'd0, 18'd0, 48'hFFFF_FFFF_FFFF, 18'd0, 1'b1, 2'b10, 48'h0);
    run("sub_extreme",     18'h20000, 18'h1FFFF, 48'd0, 18'd0, 1'b0, 2'b01, 48'hFFFF_FFFC_0001);

    run("pipe_add",  18'd100, 18'd7, 48'd50, 18'd6, 1'b1, 2'b00, 48'd107);
    run("pipe_sub",  18'd100, 18'd7, 48'd50, 18'd6, 1'b1, 2'b01, 48'd93);
    run("pipe_cadd", 18'd100, 18'd7, 48'd50, 18'd6, 1'b1, 2'b10, 48'd151);
    run("pipe_xor",  18'd100, 18'd7, 48'd50, 18'd6, 1'b1, 2'b11, 48'd98);

    reset_cycle("rst_mid");
    run("resume_add", 18'd100, 18'd7, 48'd50, 18'd6, 1'b1, 2'b00, 48'd107);
    run("resume_sub", 18'd100, 18'd7, 48'd50, 18'd6, 1'b1, 2'b01, 48'd93);
    run("resume_xor", 18'd3, 18'd0, 48'd0, 18'd10, 1'b0, 2'b11, 48'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
